// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32 subset datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional PERF_CNT_EN macro adds cycle and retired-instruction counters.
module multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       instrDone,
  output logic       trap,
  output logic [3:0] state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cycleCount,
  output logic [CNT_WIDTH-1:0] retiredCount
`endif
);

  // state    | meaning
  // RST      | post-reset idle, one cycle
  // FETCH    | read instruction, wait for memReady
  // DECODE   | branch target into ALUOut, dispatch on opcode
  // EXEC_R   | R-type ALU operation
  // EXEC_I   | I-type ALU operation
  // MEM_ADDR | load/store address computation
  // MEM_RD   | load access, wait for memReady
  // MEM_WR   | store access, wait for memReady
  // WB_ALU   | write ALUOut to rd
  // WB_MEM   | write MDR to rd
  // BRANCH   | compare and conditionally redirect PC
  // TRAP     | illegal instruction, held until reset
  typedef enum logic [3:0] {
    RST      = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd11
  } state_t;

  state_t state_q, state_d;

  if (CNT_WIDTH < 1) begin : g_cnt_width_check
    $error("CNT_WIDTH must be at least 1");
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= RST;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    pcWrite   = 1'b0;
    pcSrc     = 1'b0;
    irWrite   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memToReg  = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    instrDone = 1'b0;
    trap      = 1'b0;
    case (state_q)
      RST: state_d = FETCH;
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        aluSrcB = 2'b10;
        case (opcode)
          7'b0110011:             state_d = EXEC_R;
          7'b0010011:             state_d = EXEC_I;
          7'b0000011, 7'b0100011: state_d = MEM_ADDR;
          7'b1100011:             state_d = BRANCH;
          default:                state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
        state_d = WB_ALU;
      end
      EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        aluOp   = 2'b11;
        state_d = WB_ALU;
      end
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opcode == 7'b0000011) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        memRead = 1'b1;
        if (memReady) state_d = WB_MEM;
      end
      MEM_WR: begin
        memWrite = 1'b1;
        if (memReady) begin
          instrDone = 1'b1;
          state_d   = FETCH;
        end
      end
      WB_ALU: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH;
      end
      WB_MEM: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b01;
        pcSrc   = 1'b1;
        // Only beq/bne are legal; other funct3 encodings retire nothing and trap.
        case (funct3)
          3'b000: begin
            pcWrite   = zero;
            instrDone = 1'b1;
            state_d   = FETCH;
          end
          3'b001: begin
            pcWrite   = ~zero;
            instrDone = 1'b1;
            state_d   = FETCH;
          end
          default: state_d = TRAP;
        endcase
      end
      TRAP:    trap = 1'b1;
      default: state_d = RST;
    endcase
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cycleCount   <= '0;
      retiredCount <= '0;
    end else begin
      if (state_q != RST && state_q != TRAP) cycleCount <= cycleCount + 1'b1;
      if (instrDone) retiredCount <= retiredCount + 1'b1;
    end
  end
`endif

endmodule
